// File: rtl/body_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : body_frame_scheduler
//  Purpose  : Avalon-MM slave holding double-buffered body parameters
//             (radius, x, y, z). A CPU commit is applied atomically on the
//             next VSYNC rise, then the active set is streamed to the sprite
//             renderer over a valid/ready handshake once per frame.
//  Revision : 1.0  initial release
// ============================================================================
module body_frame_scheduler #(
    parameter int NUM_BODIES = 4,
    parameter int COORD_W    = 10
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               AVL_READ,
    input  logic               AVL_WRITE,
    input  logic               AVL_CS,
    input  logic [3:0]         AVL_BYTE_EN,
    input  logic [4:0]         AVL_ADDR,
    input  logic [31:0]        AVL_WRITEDATA,
    output logic [31:0]        AVL_READDATA,
    input  logic               VSYNC,
    output logic               BODY_VALID,
    input  logic               BODY_READY,
    output logic [2:0]         BODY_IDX,
    output logic [COORD_W-1:0] BODY_R,
    output logic [COORD_W-1:0] BODY_X,
    output logic [COORD_W-1:0] BODY_Y,
    output logic [COORD_W-1:0] BODY_Z,
    output logic               FRAME_DONE
);

    // Storage is sized for the largest legal body count so that 3-bit body
    // indices address the arrays exactly; rows beyond NUM_BODIES stay zero.
    localparam int         c_MAX_BODIES = 8;
    localparam logic [2:0] c_LAST_IDX   = 3'(NUM_BODIES - 1);
    localparam logic [5:0] c_BODY_END   = 6'(4 + 4 * NUM_BODIES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    logic               r_vs_q;
    logic               w_vs_rise;
    logic               r_enable;
    logic               r_commit_pending;
    logic               r_overrun;
    logic [7:0]         r_frame_count;
    logic [COORD_W-1:0] r_shadow [0:c_MAX_BODIES-1][0:3];
    logic [COORD_W-1:0] r_active [0:c_MAX_BODIES-1][0:3];

    logic               w_wr;
    logic               w_rd;
    logic               w_ctrl_wr;
    logic               w_body_sel;
    logic [2:0]         w_body;
    logic [1:0]         w_field;
    logic [31:0]        w_bit_mask;
    logic               w_busy;
    logic               w_unused;

    assign w_wr       = AVL_CS && AVL_WRITE;
    assign w_rd       = AVL_CS && AVL_READ;
    assign w_ctrl_wr  = w_wr && (AVL_ADDR == 5'd0) && AVL_BYTE_EN[0];
    assign w_body     = AVL_ADDR[4:2] - 3'd1;
    assign w_field    = AVL_ADDR[1:0];
    assign w_body_sel = (AVL_ADDR[4:2] != 3'd0) && ({1'b0, AVL_ADDR} < c_BODY_END);
    assign w_bit_mask = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}},
                         {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};
    assign w_vs_rise  = VSYNC && !r_vs_q;
    assign w_busy     = (r_state != S_IDLE);
    // Write-data lanes above COORD_W carry no storage.
    assign w_unused   = ^{w_bit_mask, AVL_WRITEDATA};

    // Shadow set: byte-lane writes from the CPU, allowed at any time.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int b = 0; b < c_MAX_BODIES; b++)
                for (int f = 0; f < 4; f++)
                    r_shadow[b][f] <= '0;
        end else if (w_wr && w_body_sel) begin
            r_shadow[w_body][w_field] <=
                (r_shadow[w_body][w_field] & ~w_bit_mask[COORD_W-1:0]) |
                (AVL_WRITEDATA[COORD_W-1:0] & w_bit_mask[COORD_W-1:0]);
        end
    end

    // Active set: copied wholesale only in the COMMIT cycle (pre-write shadow).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int b = 0; b < c_MAX_BODIES; b++)
                for (int f = 0; f < 4; f++)
                    r_active[b][f] <= '0;
        end else if (r_state == S_COMMIT) begin
            r_active <= r_shadow;
        end
    end

    // Control/status flags; a set request always wins over a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vs_q           <= 1'b0;
            r_enable         <= 1'b0;
            r_commit_pending <= 1'b0;
            r_overrun        <= 1'b0;
            r_frame_count    <= 8'd0;
        end else begin
            r_vs_q <= VSYNC;
            if (w_ctrl_wr)
                r_enable <= AVL_WRITEDATA[0];
            if (w_ctrl_wr && AVL_WRITEDATA[1])
                r_commit_pending <= 1'b1;
            else if (r_state == S_COMMIT)
                r_commit_pending <= 1'b0;
            if (w_vs_rise && w_busy)
                r_overrun <= 1'b1;
            else if (w_ctrl_wr && AVL_WRITEDATA[2])
                r_overrun <= 1'b0;
            if (r_state == S_COMMIT)
                r_frame_count <= r_frame_count + 8'd1;
        end
    end

    // Frame sequencer state and body index registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Frame sequencer next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        BODY_VALID   = 1'b0;
        FRAME_DONE   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_vs_rise && r_enable) begin
                    w_state_next = r_commit_pending ? S_COMMIT : S_STREAM;
                    w_idx_next   = 3'd0;
                end
            end
            S_COMMIT: begin
                w_state_next = S_STREAM;
                w_idx_next   = 3'd0;
            end
            S_STREAM: begin
                BODY_VALID = 1'b1;
                if (BODY_READY) begin
                    if (r_idx == c_LAST_IDX)
                        w_state_next = S_DONE;
                    else
                        w_idx_next = r_idx + 3'd1;
                end
            end
            S_DONE: begin
                FRAME_DONE   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign BODY_IDX = r_idx;
    assign BODY_R   = r_active[r_idx][0];
    assign BODY_X   = r_active[r_idx][1];
    assign BODY_Y   = r_active[r_idx][2];
    assign BODY_Z   = r_active[r_idx][3];

    // Combinational register read mux; zero when not selected for read.
    always_comb begin
        AVL_READDATA = 32'd0;
        if (w_rd) begin
            if (AVL_ADDR == 5'd0)
                AVL_READDATA = {31'd0, r_enable};
            else if (AVL_ADDR == 5'd1)
                AVL_READDATA = {16'd0, r_frame_count, 5'd0, r_overrun, w_busy, r_commit_pending};
            else if (w_body_sel)
                AVL_READDATA = 32'(r_shadow[w_body][w_field]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_body_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_body_frame_scheduler
//  Purpose  : Self-checking bench for body_frame_scheduler: register vector
//             table, directed frame sequences and randomized traffic against
//             a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_body_frame_scheduler;

    localparam int N  = 4;
    localparam int CW = 10;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic          rd = 1'b0, wr = 1'b0, cs = 1'b0;
    logic [3:0]    be = 4'h0;
    logic [4:0]    addr = 5'd0;
    logic [31:0]   wd = 32'd0;
    logic [31:0]   AVL_READDATA;
    logic          vsync = 1'b0;
    logic          BODY_VALID;
    logic          ready = 1'b0;
    logic [2:0]    BODY_IDX;
    logic [CW-1:0] BODY_R, BODY_X, BODY_Y, BODY_Z;
    logic          FRAME_DONE;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    body_frame_scheduler #(.NUM_BODIES(N), .COORD_W(CW)) dut (
        .CLK(CLK), .RESET(rst),
        .AVL_READ(rd), .AVL_WRITE(wr), .AVL_CS(cs), .AVL_BYTE_EN(be),
        .AVL_ADDR(addr), .AVL_WRITEDATA(wd), .AVL_READDATA(AVL_READDATA),
        .VSYNC(vsync), .BODY_VALID(BODY_VALID), .BODY_READY(ready),
        .BODY_IDX(BODY_IDX), .BODY_R(BODY_R), .BODY_X(BODY_X),
        .BODY_Y(BODY_Y), .BODY_Z(BODY_Z), .FRAME_DONE(FRAME_DONE)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_sh  [0:7][0:3];
    logic [31:0] m_act [0:7][0:3];
    bit m_en, m_pend, m_ovr, m_done, m_prev_vs, m_live;
    int m_fc, m_gap;
    int m_q[$];   // body indices still to be accepted this frame

    function automatic bit m_busy();
        return (m_gap != 0) || (m_q.size() != 0) || m_done;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0) return {31'd0, m_en};
        if (ai == 1) return 32'((m_fc << 8) | (int'(m_ovr) << 2) | (int'(m_busy()) << 1) | int'(m_pend));
        if (ai >= 4 && ai < 4 + 4 * N) return m_sh[(ai - 4) / 4][(ai - 4) % 4];
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int b = 0; b < 8; b++)
            for (int f = 0; f < 4; f++) begin
                m_sh[b][f] = 0;
                m_act[b][f] = 0;
            end
        m_en = 0; m_pend = 0; m_ovr = 0; m_done = 0; m_prev_vs = 0;
        m_fc = 0; m_gap = 0;
        m_q.delete();
    endtask

    task automatic m_step();
        bit vs_rise, busy, wrv, ctrl;
        int ai;
        logic [31:0] v;
        if (rst) begin
            m_reset();
            m_live = 1;
            return;
        end
        vs_rise = vsync && !m_prev_vs;
        busy    = m_busy();
        wrv     = cs && wr;
        ctrl    = wrv && (addr == 5'd0) && be[0];
        if (busy && vs_rise) m_ovr = 1;
        else if (ctrl && wd[2]) m_ovr = 0;
        if (m_done) m_done = 0;
        else if (m_gap != 0) begin
            m_act = m_sh;
            m_pend = 0;
            m_fc = (m_fc + 1) % 256;
            m_gap = 0;
        end else if (m_q.size() != 0) begin
            if (ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1;
            end
        end else if (vs_rise && m_en) begin
            for (int i = 0; i < N; i++) m_q.push_back(i);
            m_gap = m_pend ? 1 : 0;
        end
        if (ctrl) begin
            m_en = wd[0];
            if (wd[1]) m_pend = 1;
        end
        ai = int'(addr);
        if (wrv && ai >= 4 && ai < 4 + 4 * N) begin
            v = m_sh[(ai - 4) / 4][(ai - 4) % 4];
            for (int l = 0; l < 4; l++)
                if (be[l]) v[l*8 +: 8] = wd[l*8 +: 8];
            m_sh[(ai - 4) / 4][(ai - 4) % 4] = v & ((32'd1 << CW) - 32'd1);
        end
        m_prev_vs = vsync;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare against model, take the edge, advance the model.
    task automatic tick();
        bit ev;
        int i;
        #1;
        if (m_live) begin
            ev = (m_gap == 0) && (m_q.size() != 0);
            chk("model_valid", {31'd0, BODY_VALID}, {31'd0, ev});
            chk("model_frame_done", {31'd0, FRAME_DONE}, {31'd0, m_done});
            if (ev) begin
                i = m_q[0];
                chk("model_idx", 32'(BODY_IDX), 32'(i));
                chk("model_r", 32'(BODY_R), m_act[i][0]);
                chk("model_x", 32'(BODY_X), m_act[i][1]);
                chk("model_y", 32'(BODY_Y), m_act[i][2]);
                chk("model_z", 32'(BODY_Z), m_act[i][3]);
            end
            chk("model_readdata", AVL_READDATA, (cs && rd) ? m_read(addr) : 32'd0);
        end
        @(posedge CLK);
        m_step();
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1; wr = 1; rd = 0; addr = a; wd = d; be = b;
        tick();
        cs = 0; wr = 0; be = 4'h0;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        cs = 1; rd = 1; wr = 0; addr = a;
        #1;
        chk(name, AVL_READDATA, exp);
        tick();
        cs = 0; rd = 0;
    endtask

    task automatic vs_pulse();
        vsync = 1;
        tick();
        vsync = 0;
    endtask

    typedef struct {
        bit          do_wr;
        logic [4:0]  a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [0:10];

    initial begin
        vecs[0]  = '{0, 5'd1,  4'h0, 32'h0,        32'h0,   "rst_status"};
        vecs[1]  = '{0, 5'd13, 4'h0, 32'h0,        32'h0,   "rst_body2_x"};
        vecs[2]  = '{1, 5'd13, 4'h1, 32'h0000_0155, 32'h055, "x2_lane0"};
        vecs[3]  = '{1, 5'd13, 4'h2, 32'h0000_0200, 32'h255, "x2_lane1"};
        vecs[4]  = '{1, 5'd2,  4'hF, 32'hFFFF_FFFF, 32'h0,   "reserved"};
        vecs[5]  = '{1, 5'd20, 4'hF, 32'hFFFF_FFFF, 32'h0,   "beyond_bodies"};
        vecs[6]  = '{1, 5'd4,  4'hF, 32'hFFFF_FFFF, 32'h3FF, "trunc_coord"};
        vecs[7]  = '{1, 5'd4,  4'h4, 32'h0,        32'h3FF, "lane2_no_effect"};
        vecs[8]  = '{1, 5'd4,  4'h3, 32'h0,        32'h0,   "lanes01_clear"};
        vecs[9]  = '{1, 5'd0,  4'h0, 32'h7,        32'h0,   "ctrl_be0_off"};
        vecs[10] = '{0, 5'd1,  4'h0, 32'h0,        32'h0,   "status_idle"};

        m_live = 0;
        m_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_valid", {31'd0, BODY_VALID}, 32'd0);
        chk("rst_frame_done", {31'd0, FRAME_DONE}, 32'd0);
        chk("rst_readdata_idle", AVL_READDATA, 32'd0);

        // Register access table
        for (int k = 0; k < 11; k++) begin
            if (vecs[k].do_wr) wr_reg(vecs[k].a, vecs[k].d, vecs[k].b);
            rd_chk(vecs[k].a, vecs[k].exp, vecs[k].name);
        end

        // Commit and full stream
        wr_reg(5'd9, 32'h1AB, 4'hF);
        wr_reg(5'd0, 32'h3, 4'h1);
        rd_chk(5'd1, 32'h1, "status_pending");
        ready = 1;
        vs_pulse();
        chk("commit_cycle_no_valid", {31'd0, BODY_VALID}, 32'd0);
        tick();
        for (int k = 0; k < N; k++) begin
            chk("stream_valid", {31'd0, BODY_VALID}, 32'd1);
            chk("stream_idx", 32'(BODY_IDX), 32'(k));
            if (k == 1) chk("stream_x1", 32'(BODY_X), 32'h1AB);
            if (k == 2) chk("stream_x2", 32'(BODY_X), 32'h255);
            tick();
        end
        chk("frame_done_pulse", {31'd0, FRAME_DONE}, 32'd1);
        tick();
        chk("frame_done_once", {31'd0, FRAME_DONE}, 32'd0);
        rd_chk(5'd1, 32'h100, "status_after_frame");

        // Stall hold, overrun on second rise, no restart
        ready = 0;
        vs_pulse();
        chk("nocommit_latency", {31'd0, BODY_VALID}, 32'd1);
        chk("nocommit_idx0", 32'(BODY_IDX), 32'd0);
        ready = 1;
        tick();
        ready = 0;
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", {31'd0, BODY_VALID}, 32'd1);
            chk("stall_idx", 32'(BODY_IDX), 32'd1);
            chk("stall_x", 32'(BODY_X), 32'h1AB);
            if (s == 2) vsync = 1;
            tick();
            vsync = 0;
        end
        rd_chk(5'd1, 32'h106, "status_overrun");
        chk("no_restart_idx", 32'(BODY_IDX), 32'd1);
        ready = 1;
        tick(); tick(); tick();
        chk("stall_frame_done", {31'd0, FRAME_DONE}, 32'd1);
        tick();
        wr_reg(5'd0, 32'h5, 4'h1);
        rd_chk(5'd1, 32'h100, "status_ovr_cleared");

        // Shadow write during the COMMIT cycle
        wr_reg(5'd0, 32'h3, 4'h1);
        vs_pulse();
        wr_reg(5'd4, 32'h7, 4'hF);
        chk("active_pre_write", 32'(BODY_R), 32'h0);
        for (int k = 0; k < N + 1; k++) tick();
        rd_chk(5'd4, 32'h7, "shadow_post_write");
        rd_chk(5'd1, 32'h200, "status_frame2");

        // COMMIT request during the COMMIT cycle stays pending
        wr_reg(5'd0, 32'h3, 4'h1);
        vs_pulse();
        wr_reg(5'd0, 32'h3, 4'h1);
        chk("radius_committed", 32'(BODY_R), 32'h7);
        rd_chk(5'd1, 32'h303, "status_commit_wins");
        for (int k = 0; k < 4; k++) tick();
        vs_pulse();
        for (int k = 0; k < 6; k++) tick();
        rd_chk(5'd1, 32'h400, "status_frame4");

        // Reset in the middle of a stream
        vs_pulse();
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("reset_mid_stream", {31'd0, BODY_VALID}, 32'd0);
        rd_chk(5'd1, 32'h0, "status_after_reset");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst   = ($urandom_range(0, 999) == 0);
            ready = ($urandom_range(0, 3) != 0);
            vsync = ($urandom_range(0, 24) == 0);
            r     = int'($urandom_range(0, 9));
            addr  = 5'($urandom_range(0, 31));
            be    = 4'($urandom_range(0, 15));
            wd    = $urandom;
            cs    = (r != 9);
            wr    = (r < 3);
            rd    = (r >= 3 && r < 7) || (r == 9);
            if (wr && $urandom_range(0, 3) == 0) begin
                addr  = 5'd0;
                be[0] = 1'b1;
                wd[0] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        cs = 0; wr = 0; rd = 0; rst = 0; vsync = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
